fetch_unit: RTL and testbench

Instruction fetch stage of the arriskv core: owns the program counter, issues word-aligned requests to instruction memory, and buffers returned instructions in a small in-order FIFO for decode. It consumes the redirect produced by the branch unit (taken flag plus target PC): pending fetches are discarded and fetching restarts at the target. Sits between instruction memory and decode.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage port bundle: branch redirect, instruction memory and decode handshakes.
// Latency: none, wires only.
// Backpressure: carried by i_imem_gnt (memory side) and i_instr_ready (decode side).
interface fetch_unit_if #(
    parameter int wd_regs_p = 32
);
    logic                 i_br_taken;
    logic [wd_regs_p-1:0] i_br_pc;
    logic                 o_imem_req;
    logic [wd_regs_p-1:0] o_imem_addr;
    logic                 i_imem_gnt;
    logic                 i_imem_rvalid;
    logic [31:0]          i_imem_rdata;
    logic                 o_instr_valid;
    logic [31:0]          o_instr;
    logic [wd_regs_p-1:0] o_instr_pc;
    logic                 i_instr_ready;

    // fetch unit side
    modport master (
        input  i_br_taken, i_br_pc, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_instr_ready,
        output o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
    );

    // environment side: branch unit, instruction memory, decode
    modport slave (
        output i_br_taken, i_br_pc, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_instr_ready,
        input  o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Generic in-order FIFO with synchronous flush; storage cleared on reset.
// Latency: a push is visible at the head the cycle after (registered, no bypass).
// Backpressure: none internally; the caller never pushes into a full FIFO without popping.
module fetch_fifo #(
    parameter int width_p = 32,
    parameter int depth_p = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [width_p-1:0]       push_dat,
    input  logic                     pop_vld,
    output logic [width_p-1:0]       head_dat,
    output logic [$clog2(depth_p):0] cnt
);
    localparam int aw_lp = $clog2(depth_p);

    logic [width_p-1:0] mem_q [depth_p];
    logic [aw_lp-1:0]   wr_ptr_q;
    logic [aw_lp-1:0]   rd_ptr_q;
    logic [aw_lp:0]     cnt_q;

    assign head_dat = mem_q[rd_ptr_q];
    assign cnt      = cnt_q;

    // storage: cleared on reset so an empty FIFO presents an all-zero head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth_p; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_vld && !flush) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // pointers and occupancy; flush empties the FIFO and overrides push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr_q <= wr_ptr_q + aw_lp'(1);
            end
            if (pop_vld) begin
                rd_ptr_q <= rd_ptr_q + aw_lp'(1);
            end
            if (push_vld && !pop_vld) begin
                cnt_q <= cnt_q + (aw_lp + 1)'(1);
            end else if (!push_vld && pop_vld) begin
                cnt_q <= cnt_q - (aw_lp + 1)'(1);
            end
        end
    end
endmodule

// Instruction fetch: owns the PC, issues word requests, buffers returned words for decode.
// Latency: grant at t, response at t+L, instruction valid to decode at t+L+1.
// Backpressure: requests stop once in-flight plus buffered reaches depth_p; redirect masks valid.
module fetch_unit #(
    parameter int                   wd_regs_p  = 32,
    parameter logic [wd_regs_p-1:0] reset_pc_p = '0,
    parameter int                   depth_p    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int cw_lp = $clog2(depth_p) + 1;

    typedef struct packed {
        logic [31:0]          instr;
        logic [wd_regs_p-1:0] pc;
    } instr_ent_t;

    logic [wd_regs_p-1:0] pc_q;
    logic [wd_regs_p-1:0] rsp_pc;
    logic [wd_regs_p-1:0] br_target;
    logic [cw_lp-1:0]     out_cnt;
    logic [cw_lp-1:0]     out_cnt_nxt;
    logic [cw_lp-1:0]     fifo_cnt;
    logic [cw_lp-1:0]     drop_cnt_q;
    logic                 credit_ok;
    logic                 imem_req;
    logic                 gnt_fire;
    logic                 redirect;
    logic                 rsp_vld;
    logic                 rsp_drop;
    logic                 rsp_push;
    logic                 instr_vld;
    logic                 instr_pop;
    instr_ent_t           push_ent;
    instr_ent_t           head_ent;

    assign redirect  = bus.i_br_taken;
    assign br_target = bus.i_br_pc & ~wd_regs_p'(3);
    assign rsp_vld   = bus.i_imem_rvalid;

    // Every granted request owns a FIFO slot: in-flight plus buffered never exceeds depth_p.
    // Request is gated by reset so the port is quiet while held in reset.
    assign credit_ok = ({1'b0, out_cnt} + {1'b0, fifo_cnt}) < (cw_lp + 1)'(depth_p);
    assign imem_req  = rst_n && credit_ok;
    assign gnt_fire  = imem_req && bus.i_imem_gnt;

    // Responses owed to requests issued before the last redirect are swallowed.
    assign rsp_drop    = rsp_vld && (drop_cnt_q != '0);
    assign rsp_push    = rsp_vld && !rsp_drop && !redirect;
    assign out_cnt_nxt = out_cnt + cw_lp'(gnt_fire) - cw_lp'(rsp_vld);

    assign instr_vld = (fifo_cnt != '0) && !redirect;
    assign instr_pop = instr_vld && bus.i_instr_ready;

    assign push_ent.instr = bus.i_imem_rdata;
    assign push_ent.pc    = rsp_pc;

    assign bus.o_imem_req    = imem_req;
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_instr_valid = instr_vld;
    assign bus.o_instr       = head_ent.instr;
    assign bus.o_instr_pc    = head_ent.pc;

    // Address of every granted request, popped as its response returns; its occupancy
    // doubles as the in-flight count.
    fetch_fifo #(
        .width_p (wd_regs_p),
        .depth_p (depth_p)
    ) u_pc_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push_vld (gnt_fire),
        .push_dat (pc_q),
        .pop_vld  (rsp_vld),
        .head_dat (rsp_pc),
        .cnt      (out_cnt)
    );

    // Returned instructions awaiting decode; a redirect discards everything buffered.
    fetch_fifo #(
        .width_p ($bits(instr_ent_t)),
        .depth_p (depth_p)
    ) u_instr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push_vld (rsp_push),
        .push_dat (push_ent),
        .pop_vld  (instr_pop),
        .head_dat (head_ent),
        .cnt      (fifo_cnt)
    );

    // program counter: redirect target wins, otherwise advance one word per grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= reset_pc_p;
        end else if (redirect) begin
            pc_q <= br_target;
        end else if (gnt_fire) begin
            pc_q <= pc_q + wd_regs_p'(4);
        end
    end

    // discard counter: a redirect marks every request still outstanding after this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (redirect) begin
            drop_cnt_q <= out_cnt_nxt;
        end else if (rsp_drop) begin
            drop_cnt_q <= drop_cnt_q - cw_lp'(1);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, address model, stream scoreboard.
// Latency: memory latency programmable 1..4 cycles.
// Backpressure: grant and decode-ready randomised in the soak phase.
module tb_fetch_unit;
    localparam int          WD     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_pops   = 0;
    int n_grants = 0;
    int cyc      = 0;
    int lat      = 1;

    exp_t        exp_q[$];
    mreq_t       mq[$];
    logic [31:0] exp_addr = RST_PC;

    always #5 clk = ~clk;

    fetch_unit_if #(.wd_regs_p(WD)) bus ();

    fetch_unit #(
        .wd_regs_p  (WD),
        .reset_pc_p (RST_PC),
        .depth_p    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // instruction word stored at a given address
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // decode must see a sequential stream starting at the (word-aligned) start address
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] p;
        exp_t        e;
        p = start & ~32'h3;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            e.pc    = p;
            e.instr = mdata(p);
            exp_q.push_back(e);
            p = p + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_first_pop(input string name, input logic [31:0] exp_pc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            sample();
            if (bus.o_instr_valid && bus.i_instr_ready) begin
                got = 1'b1;
                chk(name, bus.o_instr_pc, exp_pc);
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no instruction within 30 cycles, expected pc %h", name, exp_pc);
        end
    endtask

    // memory response driver: one in-order response per cycle once its latency has elapsed
    initial begin : mem_drv
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
                bus.i_imem_rvalid = 1'b1;
                bus.i_imem_rdata  = mdata(mq[0].addr);
            end else begin
                bus.i_imem_rvalid = 1'b0;
            end
        end
    end

    // memory bookkeeping and expected fetch address
    initial begin : mem_mon
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                exp_addr = RST_PC;
            end else begin
                if (bus.i_imem_rvalid && mq.size() > 0) begin
                    void'(mq.pop_front());
                end
                if (bus.o_imem_req) begin
                    chk("imem_addr", bus.o_imem_addr, exp_addr);
                end
                if (bus.o_imem_req && bus.i_imem_gnt) begin
                    mq.push_back('{addr: bus.o_imem_addr, due: cyc + lat});
                    n_grants++;
                end
                if (bus.i_br_taken) begin
                    exp_addr = bus.i_br_pc & ~32'h3;
                end else if (bus.o_imem_req && bus.i_imem_gnt) begin
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
    end

    // decode-side monitor: every accepted instruction against the scoreboard
    initial begin : dec_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.i_br_taken) begin
                    chkb("valid_during_redirect", bus.o_instr_valid, 1'b0);
                end
                if (bus.o_instr_valid && bus.i_instr_ready) begin
                    n_pops++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_instr: got pc %h with nothing expected", bus.o_instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_pc", bus.o_instr_pc, e.pc);
                        chk("instr", bus.o_instr, e.instr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: run did not reach the end, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          p0;
        logic [31:0] a0;

        rst_n             = 1'b0;
        bus.i_br_taken    = 1'b0;
        bus.i_br_pc       = '0;
        bus.i_imem_gnt    = 1'b0;
        bus.i_instr_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        sample();
        chkb("reset_req", bus.o_imem_req, 1'b0);
        chk("reset_addr", bus.o_imem_addr, RST_PC);
        chkb("reset_valid", bus.o_instr_valid, 1'b0);
        chk("reset_instr", bus.o_instr, 32'h0);
        chk("reset_instr_pc", bus.o_instr_pc, 32'h0);

        // release: request immediately, first instruction two cycles after first grant
        tick();
        load_stream(RST_PC);
        rst_n             = 1'b1;
        bus.i_imem_gnt    = 1'b1;
        bus.i_instr_ready = 1'b1;
        sample();
        chkb("first_req", bus.o_imem_req, 1'b1);
        chk("first_addr", bus.o_imem_addr, RST_PC);
        sample();
        chkb("valid_after_1", bus.o_instr_valid, 1'b0);
        sample();
        chkb("valid_after_2", bus.o_instr_valid, 1'b1);
        chk("first_instr_pc", bus.o_instr_pc, RST_PC);

        // sustained one instruction per cycle
        p0 = n_pops;
        repeat (20) sample();
        chk("throughput", 32'(n_pops - p0), 32'd20);

        // decode stalled: requests stop once depth_p words are owed or buffered
        tick();
        bus.i_instr_ready = 1'b0;
        repeat (10) sample();
        chkb("stall_req", bus.o_imem_req, 1'b0);
        chk("stall_outstanding", 32'(n_grants - n_pops), 32'(DEPTH));
        chkb("stall_valid", bus.o_instr_valid, 1'b1);
        tick();
        bus.i_instr_ready = 1'b1;
        sample();
        sample();
        chkb("resume_req", bus.o_imem_req, 1'b1);

        // redirect with several requests in flight at latency 3
        tick();
        lat = 3;
        repeat (8) tick();
        bus.i_br_taken = 1'b1;
        bus.i_br_pc    = 32'h0000_0103;
        load_stream(32'h0000_0103);
        tick();
        bus.i_br_taken = 1'b0;
        sample();
        chk("redirect_addr", bus.o_imem_addr, 32'h0000_0100);
        wait_first_pop("redirect_first_pc", 32'h0000_0100);

        // redirect coinciding with a grant and a response
        tick();
        lat = 1;
        repeat (10) tick();
        bus.i_br_taken = 1'b1;
        bus.i_br_pc    = 32'h0000_0200;
        load_stream(32'h0000_0200);
        sample();
        chkb("overlap_gnt_rvalid", bus.o_imem_req && bus.i_imem_gnt && bus.i_imem_rvalid, 1'b1);
        chkb("overlap_valid", bus.o_instr_valid, 1'b0);
        tick();
        bus.i_br_taken = 1'b0;
        wait_first_pop("overlap_first_pc", 32'h0000_0200);

        // grant withheld: address holds, then a redirect replaces it
        tick();
        bus.i_imem_gnt = 1'b0;
        sample();
        a0 = exp_addr;
        repeat (5) begin
            sample();
            chk("gnt_stall_addr", bus.o_imem_addr, a0);
        end
        tick();
        bus.i_br_taken = 1'b1;
        bus.i_br_pc    = 32'h0000_0300;
        load_stream(32'h0000_0300);
        tick();
        bus.i_br_taken = 1'b0;
        sample();
        chk("stall_redirect_addr", bus.o_imem_addr, 32'h0000_0300);
        chkb("stall_redirect_req", bus.o_imem_req, 1'b1);
        tick();
        bus.i_imem_gnt = 1'b1;
        wait_first_pop("stall_first_pc", 32'h0000_0300);

        // PC wraps past the top of the address space
        tick();
        bus.i_br_taken = 1'b1;
        bus.i_br_pc    = 32'hFFFF_FFF9;
        load_stream(32'hFFFF_FFF9);
        tick();
        bus.i_br_taken = 1'b0;
        sample();
        chk("wrap_addr0", bus.o_imem_addr, 32'hFFFF_FFF8);
        sample();
        chk("wrap_addr1", bus.o_imem_addr, 32'hFFFF_FFFC);
        sample();
        chk("wrap_addr2", bus.o_imem_addr, 32'h0000_0000);

        // randomised soak: grant/ready backpressure, redirects (incl. back-to-back), latency 1..4
        for (int c = 0; c < 1500; c++) begin
            tick();
            bus.i_instr_ready = ($urandom % 4) != 0;
            bus.i_imem_gnt    = ($urandom % 10) < 7;
            if (($urandom % 20) == 0) begin
                bus.i_br_taken = 1'b1;
                bus.i_br_pc    = $urandom;
                load_stream(bus.i_br_pc);
            end else begin
                bus.i_br_taken = 1'b0;
            end
            if ((c % 100) == 0) begin
                lat = $urandom_range(1, 4);
            end
        end
        tick();
        bus.i_br_taken    = 1'b0;
        bus.i_instr_ready = 1'b1;
        bus.i_imem_gnt    = 1'b1;
        lat               = 1;

        // asynchronous reset in the middle of a burst
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chkb("arst_req", bus.o_imem_req, 1'b0);
        chk("arst_addr", bus.o_imem_addr, RST_PC);
        chkb("arst_valid", bus.o_instr_valid, 1'b0);
        chk("arst_instr", bus.o_instr, 32'h0);
        chk("arst_instr_pc", bus.o_instr_pc, 32'h0);
        repeat (2) tick();
        load_stream(RST_PC);
        rst_n = 1'b1;
        sample();
        chk("rerst_addr", bus.o_imem_addr, RST_PC);
        wait_first_pop("rerst_first_pc", RST_PC);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
